// File: rtl/gf180mcu_osu_clkdiv_if.sv
// Divide-ratio request channel for the clock divider.
// The source holds DIV_IN stable while DIV_VLD && !DIV_RDY.
interface gf180mcu_osu_clkdiv_if #(
   parameter int W = 8
);
   logic [W-1:0] DIV_IN;
   logic         DIV_VLD;
   logic         DIV_RDY;

   modport master (
      output DIV_IN,
      output DIV_VLD,
      input  DIV_RDY
   );

   modport slave (
      input  DIV_IN,
      input  DIV_VLD,
      output DIV_RDY
   );
endinterface

// File: rtl/gf180mcu_osu_clkdiv.sv
// Programmable integer clock divider with a registered, glitch-free CLKO.
// Ratio updates and stops only take effect on period boundaries.
module gf180mcu_osu_clkdiv #(
   parameter int W       = 8,
   parameter int DIV_RST = 2
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   EN,
   gf180mcu_osu_clkdiv_if.slave   div,
   output logic                   CLKO,
   output logic                   TICK,
   output logic                   ACTIVE
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [W-1:0] ONE     = W'(1);
   localparam logic [W-1:0] TWO     = W'(2);
   localparam logic [W-1:0] RST_DIV = W'(DIV_RST);

   state_t       state;
   state_t       state_n;
   logic [W-1:0] cnt;
   logic [W-1:0] cnt_n;
   logic [W-1:0] div_act;
   logic [W-1:0] div_act_n;
   logic [W-1:0] div_pend;
   logic [W-1:0] div_sat;
   logic         pend_vld;
   logic         last;
   logic         bnd;
   logic         apply;
   logic         xfer;
   logic         clko_n;

   assign last      = (cnt == div_act - ONE);
   assign bnd       = (state == IDLE) || last;
   assign apply     = bnd && pend_vld;
   assign xfer      = div.DIV_VLD && !pend_vld;
   assign div_sat   = (div.DIV_IN < TWO) ? TWO : div.DIV_IN;
   assign div_act_n = apply ? div_pend : div_act;
   assign cnt_n     = bnd ? '0 : cnt + ONE;

   // CLKO is derived from next-state values so the pin is a bare flop.
   assign clko_n = (state_n != IDLE) && (cnt_n < (div_act_n >> 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: begin
            if (EN) state_n = RUN;
         end
         RUN: begin
            if (!EN) state_n = bnd ? IDLE : DRAIN;
         end
         DRAIN: begin
            if (EN)       state_n = RUN;
            else if (bnd) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      ACTIVE      = (state != IDLE);
      TICK        = (state != IDLE) && last;
      div.DIV_RDY = !pend_vld;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt      <= '0;
         div_act  <= RST_DIV;
         div_pend <= RST_DIV;
         pend_vld <= 1'b0;
         CLKO     <= 1'b0;
      end else begin
         cnt     <= cnt_n;
         div_act <= div_act_n;
         CLKO    <= clko_n;
         // Apply uses the registered flag, so a same-cycle transfer waits.
         if (xfer) begin
            div_pend <= div_sat;
            pend_vld <= 1'b1;
         end else if (apply) begin
            pend_vld <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_gf180mcu_osu_clkdiv.sv
// Directed bench for gf180mcu_osu_clkdiv: vector table plus
// hand-written sequences for ratio change, drain, saturation and reset.
module tb_gf180mcu_osu_clkdiv;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic EN = 1'b0;
   logic CLKO;
   logic TICK;
   logic ACTIVE;
   int   checks = 0;
   int   failures = 0;

   gf180mcu_osu_clkdiv_if #(.W(8)) bus ();

   gf180mcu_osu_clkdiv #(.W(8), .DIV_RST(2)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .EN     (EN),
      .div    (bus),
      .CLKO   (CLKO),
      .TICK   (TICK),
      .ACTIVE (ACTIVE)
   );

   always #5 CLK = ~CLK;

   // exp packs {CLKO, TICK, ACTIVE, DIV_RDY} seen after the edge
   typedef struct {
      logic       en;
      logic       vld;
      logic [7:0] din;
      logic [3:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [3:0] obs();
      return {CLKO, TICK, ACTIVE, bus.DIV_RDY};
   endfunction

   task automatic chk(input string name, input logic [3:0] act,
                      input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%b want=%b (clko,tick,active,rdy)",
                  name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic step(input logic en, input logic vld, input logic [7:0] din);
      EN = en;
      bus.DIV_VLD = vld;
      bus.DIV_IN = din;
      @(posedge CLK);
      #1;
   endtask

   task automatic cyc(input string name, input logic en, input logic vld,
                      input logic [7:0] din, input logic [3:0] exp);
      step(en, vld, din);
      chk(name, obs(), exp);
   endtask

   task automatic do_reset();
      EN = 1'b0;
      bus.DIV_VLD = 1'b0;
      bus.DIV_IN = '0;
      RST = 1'b1;
      @(posedge CLK);
      #1;
      chk("reset", obs(), 4'b0001);
      #2;
      RST = 1'b0;
   endtask

   task automatic add(input logic en, input logic vld, input logic [7:0] din,
                      input logic [3:0] exp);
      vec_t v;
      v.en = en;
      v.vld = vld;
      v.din = din;
      v.exp = exp;
      tbl.push_back(v);
   endtask

   initial begin
      int hi;
      int lo;
      int tick_at;
      int ticks;

      bus.DIV_VLD = 1'b0;
      bus.DIV_IN = '0;

      // default N=2, stop, idle load of 4, run, live load of 3
      add(1, 0, 0, 4'b1011);
      add(1, 0, 0, 4'b0111);
      add(1, 0, 0, 4'b1011);
      add(1, 0, 0, 4'b0111);
      add(0, 0, 0, 4'b0001);
      add(0, 0, 0, 4'b0001);
      add(0, 1, 4, 4'b0000);
      add(0, 0, 0, 4'b0001);
      add(1, 0, 0, 4'b1011);
      add(1, 0, 0, 4'b1011);
      add(1, 0, 0, 4'b0011);
      add(1, 0, 0, 4'b0111);
      add(1, 0, 0, 4'b1011);
      add(1, 1, 3, 4'b1010);
      add(1, 0, 0, 4'b0010);
      add(1, 0, 0, 4'b0110);
      add(1, 0, 0, 4'b1011);
      add(1, 0, 0, 4'b0011);
      add(1, 0, 0, 4'b0111);
      add(1, 0, 0, 4'b1011);

      do_reset();
      foreach (tbl[i]) begin
         step(tbl[i].en, tbl[i].vld, tbl[i].din);
         chk($sformatf("tbl[%0d]", i), obs(), tbl[i].exp);
      end

      // N=6 running, load 4 at cnt=2, second request stalls
      do_reset();
      cyc("n6_load", 0, 1, 6, 4'b0000);
      cyc("n6_apply", 0, 0, 0, 4'b0001);
      cyc("n6_c0", 1, 0, 0, 4'b1011);
      cyc("n6_c1", 1, 0, 0, 4'b1011);
      cyc("n6_c2", 1, 0, 0, 4'b1011);
      cyc("n6_c3", 1, 1, 4, 4'b0010);
      cyc("n6_c4", 1, 1, 5, 4'b0010);
      cyc("n6_c5", 1, 1, 5, 4'b0110);
      cyc("n4_c0", 1, 1, 5, 4'b1011);
      cyc("n4_c1", 1, 1, 5, 4'b1010);
      cyc("n4_c2", 1, 0, 0, 4'b0010);
      cyc("n4_c3", 1, 0, 0, 4'b0110);
      cyc("n5_c0", 1, 0, 0, 4'b1011);
      cyc("n5_c1", 1, 0, 0, 4'b1011);
      cyc("n5_c2", 1, 0, 0, 4'b0011);
      cyc("n5_c3", 1, 0, 0, 4'b0011);
      cyc("n5_c4", 1, 0, 0, 4'b0111);
      cyc("n5_nx", 1, 0, 0, 4'b1011);

      // N=8 drain after EN drop, then re-raise mid-drain
      do_reset();
      cyc("n8_load", 0, 1, 8, 4'b0000);
      cyc("n8_apply", 0, 0, 0, 4'b0001);
      cyc("dr_c0", 1, 0, 0, 4'b1011);
      cyc("dr_c1", 1, 0, 0, 4'b1011);
      cyc("dr_c2", 0, 0, 0, 4'b1011);
      cyc("dr_c3", 0, 0, 0, 4'b1011);
      cyc("dr_c4", 0, 0, 0, 4'b0011);
      cyc("dr_c5", 0, 0, 0, 4'b0011);
      cyc("dr_c6", 0, 0, 0, 4'b0011);
      cyc("dr_c7", 0, 0, 0, 4'b0111);
      cyc("dr_idle", 0, 0, 0, 4'b0001);
      cyc("dr_hold", 0, 0, 0, 4'b0001);
      cyc("re_c0", 1, 0, 0, 4'b1011);
      cyc("re_c1", 1, 0, 0, 4'b1011);
      cyc("re_c2", 0, 0, 0, 4'b1011);
      cyc("re_c3", 0, 0, 0, 4'b1011);
      cyc("re_c4", 0, 0, 0, 4'b0011);
      cyc("re_c5", 0, 0, 0, 4'b0011);
      cyc("re_c6", 1, 0, 0, 4'b0011);
      cyc("re_c7", 1, 0, 0, 4'b0111);
      cyc("re_n0", 1, 0, 0, 4'b1011);
      cyc("re_n1", 1, 0, 0, 4'b1011);

      // DIV_IN of 0 and 1 saturate to 2 (after loading 5 first)
      do_reset();
      cyc("s0_ld5", 0, 1, 5, 4'b0000);
      cyc("s0_ap5", 0, 0, 0, 4'b0001);
      cyc("s0_ld0", 0, 1, 0, 4'b0000);
      cyc("s0_ap0", 0, 0, 0, 4'b0001);
      cyc("s0_c0", 1, 0, 0, 4'b1011);
      cyc("s0_c1", 1, 0, 0, 4'b0111);
      cyc("s0_c0b", 1, 0, 0, 4'b1011);
      cyc("s0_drain", 0, 0, 0, 4'b0111);
      cyc("s0_idle", 0, 0, 0, 4'b0001);
      cyc("s1_ld5", 0, 1, 5, 4'b0000);
      cyc("s1_ap5", 0, 0, 0, 4'b0001);
      cyc("s1_ld1", 0, 1, 1, 4'b0000);
      cyc("s1_ap1", 0, 0, 0, 4'b0001);
      cyc("s1_c0", 1, 0, 0, 4'b1011);
      cyc("s1_c1", 1, 0, 0, 4'b0111);
      cyc("s1_c0b", 1, 0, 0, 4'b1011);

      // N=255: high 127, low 128, single tick on the last cycle
      do_reset();
      cyc("m_load", 0, 1, 255, 4'b0000);
      cyc("m_apply", 0, 0, 0, 4'b0001);
      hi = 0;
      lo = 0;
      ticks = 0;
      tick_at = -1;
      for (int i = 0; i < 255; i++) begin
         step(1, 0, 0);
         if (CLKO) hi++;
         else lo++;
         if (TICK) begin
            ticks++;
            tick_at = i;
         end
      end
      chk_int("m_high", hi, 127);
      chk_int("m_low", lo, 128);
      chk_int("m_ticks", ticks, 1);
      chk_int("m_tick_at", tick_at, 254);
      cyc("m_next", 1, 0, 0, 4'b1011);

      // async reset at cnt=1 of N=4 with a request pending
      do_reset();
      cyc("r_load", 0, 1, 4, 4'b0000);
      cyc("r_apply", 0, 0, 0, 4'b0001);
      cyc("r_c0", 1, 0, 0, 4'b1011);
      cyc("r_c1", 1, 1, 6, 4'b1010);
      bus.DIV_VLD = 1'b0;
      #2;
      RST = 1'b1;
      #1;
      chk("r_async", obs(), 4'b0001);
      #1;
      RST = 1'b0;
      cyc("r_n2_c0", 1, 0, 0, 4'b1011);
      cyc("r_n2_c1", 1, 0, 0, 4'b0111);
      cyc("r_n2_c0b", 1, 0, 0, 4'b1011);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
